// File: rtl/sa_axi_rd_arbiter.sv
// Round-robin arbiter that shares one AXI4 read channel (AR/R) between NREQ
// requesters, granting one burst at a time and releasing the channel on RLAST.
module sa_axi_rd_arbiter #(
    parameter int NREQ = 2,
    parameter int A    = 32,
    parameter int D    = 32,
    parameter int I    = 4,
    parameter int L    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*A-1:0] req_addr,
    input  logic [NREQ*L-1:0] req_len,
    output logic [D-1:0]      rd_data,
    output logic [NREQ-1:0]   rd_valid,
    output logic              rd_last,
    input  logic [NREQ-1:0]   rd_ready,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    output logic [A-1:0]      M_ARADDR,
    output logic [I-1:0]      M_ARID,
    output logic [L-1:0]      M_ARLEN,
    output logic [2:0]        M_ARSIZE,
    output logic [1:0]        M_ARBURST,
    input  logic              M_RVALID,
    output logic              M_RREADY,
    input  logic [D-1:0]      M_RDATA,
    input  logic              M_RLAST,
    input  logic [I-1:0]      M_RID,
    input  logic [1:0]        M_RRESP,
    output logic [NREQ-1:0]   err_flag,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] NREQ_V = (PW+1)'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [PW-1:0]     grant_r;
    logic [L-1:0]      beat_cnt_r;
    logic              arvalid_r;
    logic [A-1:0]      araddr_r;
    logic [I-1:0]      arid_r;
    logic [L-1:0]      arlen_r;
    logic [NREQ-1:0]   err_r;

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [PW-1:0]     off_s;
    logic              win_found_s;
    logic [PW:0]       win_sum_s;
    logic [PW-1:0]     win_s;
    logic [PW:0]       grant_inc_s;
    logic [PW-1:0]     next_ptr_s;
    logic              rready_s;
    logic              beat_s;
    logic              beat_err_s;

    // Rotate requests so bit 0 is rr_ptr, pick the first set bit, map back.
    always_comb begin
        dbl_s       = {req_valid, req_valid} >> rr_ptr_r;
        rot_s       = dbl_s[NREQ-1:0];
        off_s       = '0;
        win_found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            off_s       = (!win_found_s && rot_s[i]) ? PW'(i) : off_s;
            win_found_s = win_found_s | rot_s[i];
        end
        win_sum_s   = {1'b0, rr_ptr_r} + {1'b0, off_s};
        win_s       = (win_sum_s >= NREQ_V) ? PW'(win_sum_s - NREQ_V) : PW'(win_sum_s);
        grant_inc_s = {1'b0, grant_r} + {{PW{1'b0}}, 1'b1};
        next_ptr_s  = (grant_inc_s == NREQ_V) ? {PW{1'b0}} : PW'(grant_inc_s);
    end

    // Request acceptance is offered only to the winner and only in IDLE.
    always_comb begin
        req_ready = '0;
        if (state_r == ST_IDLE && win_found_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // R channel steering: only the granted requester sees or back-pressures beats.
    always_comb begin
        rready_s = 1'b0;
        rd_valid = '0;
        if (state_r == ST_DATA) begin
            rready_s          = rd_ready[grant_r];
            rd_valid[grant_r] = M_RVALID;
        end else begin
            rready_s = 1'b0;
            rd_valid = '0;
        end
    end

    assign beat_s     = M_RVALID & rready_s;
    assign beat_err_s = (M_RRESP != 2'b00)
                      | (M_RID != I'(grant_r))
                      | (M_RLAST & (beat_cnt_r != arlen_r))
                      | (~M_RLAST & (beat_cnt_r == arlen_r));

    // Burst sequencing FSM with registered AR outputs and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            beat_cnt_r <= '0;
            arvalid_r  <= 1'b0;
            araddr_r   <= '0;
            arid_r     <= '0;
            arlen_r    <= '0;
            err_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_r   <= win_s;
                        araddr_r  <= req_addr[win_s*A +: A];
                        arlen_r   <= req_len[win_s*L +: L];
                        arid_r    <= I'(win_s);
                        arvalid_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arvalid_r && M_ARREADY) begin
                        arvalid_r  <= 1'b0;
                        beat_cnt_r <= '0;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + {{(L-1){1'b0}}, 1'b1};
                        if (beat_err_s) begin
                            err_r[grant_r] <= 1'b1;
                        end
                        if (M_RLAST) begin
                            rr_ptr_r <= next_ptr_s;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign M_ARVALID = arvalid_r;
    assign M_ARADDR  = araddr_r;
    assign M_ARID    = arid_r;
    assign M_ARLEN   = arlen_r;
    assign M_ARSIZE  = 3'($clog2(D/8));
    assign M_ARBURST = 2'b01;
    assign M_RREADY  = rready_s;
    assign rd_data   = M_RDATA;
    assign rd_last   = M_RLAST;
    assign err_flag  = err_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sa_axi_rd_arbiter.sv
// Directed bench for sa_axi_rd_arbiter: table-driven combinational checks plus
// hand-written burst sequences acting as a simple AXI slave.
module tb_sa_axi_rd_arbiter;

    localparam int NREQ = 2;
    localparam int A    = 32;
    localparam int D    = 32;
    localparam int I    = 4;
    localparam int L    = 8;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*A-1:0] req_addr;
    logic [NREQ*L-1:0] req_len;
    logic [D-1:0]      rd_data;
    logic [NREQ-1:0]   rd_valid;
    logic              rd_last;
    logic [NREQ-1:0]   rd_ready;
    logic              M_ARVALID;
    logic              M_ARREADY;
    logic [A-1:0]      M_ARADDR;
    logic [I-1:0]      M_ARID;
    logic [L-1:0]      M_ARLEN;
    logic [2:0]        M_ARSIZE;
    logic [1:0]        M_ARBURST;
    logic              M_RVALID;
    logic              M_RREADY;
    logic [D-1:0]      M_RDATA;
    logic              M_RLAST;
    logic [I-1:0]      M_RID;
    logic [1:0]        M_RRESP;
    logic [NREQ-1:0]   err_flag;
    logic              busy;

    sa_axi_rd_arbiter #(.NREQ(NREQ), .A(A), .D(D), .I(I), .L(L)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RLAST(M_RLAST), .M_RID(M_RID), .M_RRESP(M_RRESP),
        .err_flag(err_flag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic [1:0] exp_ready;
    } arb_vec_t;

    typedef struct {
        logic [1:0] rdy;
        logic       rvalid;
        logic       exp_rready;
        logic [1:0] exp_rdv;
    } dat_vec_t;

    arb_vec_t arb_tab [4];
    dat_vec_t dat_tab [4];

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request a burst for requester k and take it through the AR phase.
    task automatic req_grant(input int k, input logic [A-1:0] addr, input logic [L-1:0] len,
                             input int ar_delay);
        req_addr[k*A +: A] = addr;
        req_len[k*L +: L]  = len;
        req_valid          = NREQ'(1) << k;
        #1;
        check("req_ready_idle", req_ready, NREQ'(1) << k);
        step();
        check("arvalid_set", M_ARVALID, 1);
        check("req_ready_busy", req_ready, 0);
        req_valid = '0;
        check("araddr", M_ARADDR, addr);
        check("arlen", M_ARLEN, len);
        check("arid", M_ARID, k);
        check("busy_addr", busy, 1);
        for (int n = 0; n < ar_delay; n++) begin
            step();
            check("arvalid_hold", M_ARVALID, 1);
            check("araddr_hold", M_ARADDR, addr);
            check("arlen_hold", M_ARLEN, len);
        end
        M_ARREADY = 1'b1;
        step();
        M_ARREADY = 1'b0;
        check("arvalid_drop", M_ARVALID, 0);
    endtask

    // Present one R beat addressed to requester k and let it be accepted.
    task automatic beat(input int k, input logic [D-1:0] data, input logic last,
                        input logic [1:0] resp);
        M_RVALID = 1'b1;
        M_RDATA  = data;
        M_RLAST  = last;
        M_RID    = I'(k);
        M_RRESP  = resp;
        #1;
        check("rd_valid", rd_valid, NREQ'(1) << k);
        check("rd_data", rd_data, data);
        check("rd_last", rd_last, last);
        check("m_rready", M_RREADY, 1);
        step();
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        M_RRESP  = 2'b00;
    endtask

    initial begin
        arb_tab[0] = '{rv: 2'b00, exp_ready: 2'b00};
        arb_tab[1] = '{rv: 2'b01, exp_ready: 2'b01};
        arb_tab[2] = '{rv: 2'b10, exp_ready: 2'b10};
        arb_tab[3] = '{rv: 2'b11, exp_ready: 2'b01};
        dat_tab[0] = '{rdy: 2'b00, rvalid: 1'b0, exp_rready: 1'b0, exp_rdv: 2'b00};
        dat_tab[1] = '{rdy: 2'b01, rvalid: 1'b1, exp_rready: 1'b1, exp_rdv: 2'b01};
        dat_tab[2] = '{rdy: 2'b10, rvalid: 1'b1, exp_rready: 1'b0, exp_rdv: 2'b01};
        dat_tab[3] = '{rdy: 2'b11, rvalid: 1'b0, exp_rready: 1'b1, exp_rdv: 2'b00};

        rstn      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        rd_ready  = '0;
        M_ARREADY = 1'b0;
        M_RVALID  = 1'b0;
        M_RDATA   = '0;
        M_RLAST   = 1'b0;
        M_RID     = '0;
        M_RRESP   = 2'b00;
        step();
        step();
        check("rst_arvalid", M_ARVALID, 0);
        check("rst_araddr", M_ARADDR, 0);
        check("rst_arid", M_ARID, 0);
        check("rst_arlen", M_ARLEN, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_flag, 0);
        check("arsize", M_ARSIZE, 3'b010);
        check("arburst", M_ARBURST, 2'b01);
        rstn = 1'b1;
        step();

        // Arbitration table with rr_ptr=0, no clock edge applied.
        for (int v = 0; v < 4; v++) begin
            req_valid = arb_tab[v].rv;
            #1;
            check("arb_table", req_ready, arb_tab[v].exp_ready);
        end
        req_valid = '0;
        #1;

        // Single request, AR accepted after 2 cycles, 4 beats.
        req_grant(0, 32'h0000_0800, 8'd3, 1);
        for (int v = 0; v < 4; v++) begin
            rd_ready = dat_tab[v].rdy;
            M_RVALID = dat_tab[v].rvalid;
            #1;
            check("dat_table_rready", M_RREADY, dat_tab[v].exp_rready);
            check("dat_table_rdvalid", rd_valid, dat_tab[v].exp_rdv);
        end
        M_RVALID = 1'b0;
        rd_ready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            beat(0, 32'hA0 + 32'(b), b == 3, 2'b00);
        end
        check("single_busy_after", busy, 0);
        check("single_rdvalid_after", rd_valid, 0);
        check("single_err", err_flag, 0);

        // Backpressure: requester 1, len=7, 5-cycle stall after beat 3.
        req_grant(1, 32'h0000_1000, 8'd7, 0);
        rd_ready = 2'b10;
        for (int b = 0; b < 4; b++) begin
            beat(1, 32'hB0 + 32'(b), 1'b0, 2'b00);
        end
        rd_ready = 2'b00;
        M_RVALID = 1'b1;
        M_RDATA  = 32'hB4;
        M_RID    = 4'd1;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("stall_rready", M_RREADY, 0);
            check("stall_rdvalid", rd_valid, 2'b10);
            step();
        end
        rd_ready = 2'b10;
        for (int b = 4; b < 8; b++) begin
            beat(1, 32'hB0 + 32'(b), b == 7, 2'b00);
        end
        check("bp_err", err_flag, 0);
        check("bp_busy_after", busy, 0);

        // Contention with zero-length bursts: grants must alternate 0,1,0,1.
        req_len   = '0;
        rd_ready  = 2'b11;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            int t;
            t = 0;
            while (!M_ARVALID && t < 20) begin
                step();
                t++;
            end
            check("arvalid_wait", t < 20, 1);
            check("contention_arid", M_ARID, n % 2);
            M_ARREADY = 1'b1;
            step();
            M_ARREADY = 1'b0;
            beat(n % 2, 32'hC0 + 32'(n), 1'b1, 2'b00);
        end
        req_valid = '0;
        #1;
        check("contention_err", err_flag, 0);

        // Error response on beat 2 of requester 0.
        req_grant(0, 32'h0000_2000, 8'd3, 0);
        rd_ready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            beat(0, 32'hD0 + 32'(b), b == 3, (b == 2) ? 2'b10 : 2'b00);
            if (b >= 2) check("rresp_err_sticky", err_flag, 2'b01);
            else        check("rresp_err_clean", err_flag, 2'b00);
        end
        check("rresp_busy_after", busy, 0);

        // Early RLAST on beat 1 of requester 1.
        req_grant(1, 32'h0000_3000, 8'd3, 0);
        rd_ready = 2'b10;
        beat(1, 32'hE0, 1'b0, 2'b00);
        check("early_err_clean", err_flag, 2'b01);
        beat(1, 32'hE1, 1'b1, 2'b00);
        check("early_err_set", err_flag, 2'b11);
        check("early_busy_after", busy, 0);

        // Move rr_ptr to 1, then reset during a burst of requester 1.
        req_grant(0, 32'h0000_4000, 8'd0, 0);
        rd_ready = 2'b01;
        beat(0, 32'hF0, 1'b1, 2'b00);
        req_grant(1, 32'h0000_5000, 8'd3, 0);
        rd_ready = 2'b10;
        beat(1, 32'hF1, 1'b0, 2'b00);
        beat(1, 32'hF2, 1'b0, 2'b00);
        M_RVALID = 1'b1;
        M_RID    = 4'd1;
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_arvalid", M_ARVALID, 0);
        check("rst_mid_rready", M_RREADY, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_err", err_flag, 0);
        check("rst_mid_rdvalid", rd_valid, 0);
        M_RVALID = 1'b0;
        step();
        rstn = 1'b1;
        req_valid = 2'b11;
        #1;
        check("post_rst_ptr", req_ready, 2'b01);
        req_valid = '0;
        #1;
        req_grant(1, 32'h0000_6000, 8'd0, 0);
        beat(1, 32'h55, 1'b1, 2'b00);
        check("post_rst_err", err_flag, 0);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
